serial_frame_rx: RTL and testbench



---
 rtl/serial_frame_rx_pkg.sv | 29 ++
 rtl/serial_frame_rx_bit_counter.sv | 40 ++++
 rtl/serial_frame_rx.sv | 156 +++++++++++++++
 tb/tb_serial_frame_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_rx_pkg.sv
// ---------------------------------------------------------------------------
// serial_frame_rx_pkg
// Shared definitions for the framed serial receive path and its matching
// transmit sequencer.
//   rx_state_t   : receiver FSM state encoding
//   START_BIT    : line level that opens a frame
//   STOP_BIT     : line level expected at the end of a frame
//   IDLE_LEVEL   : line level between frames
//   count_width  : bits needed for a counter that must reach a given value
// ---------------------------------------------------------------------------
package serial_frame_rx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   localparam logic START_BIT  = 1'b1;
   localparam logic STOP_BIT   = 1'b0;
   localparam logic IDLE_LEVEL = 1'b0;

   // Counter width able to hold every value 0..max_value inclusive
   function automatic int count_width(input int max_value);
      return $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/serial_frame_rx_bit_counter.sv
// ---------------------------------------------------------------------------
// rx_bit_counter
// Clearable, enabled up-counter that tracks how many data bits of the
// current frame have been received.
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset, count returns to 0
//   clear    : synchronous clear, has priority over enable
//   enable   : advance the count by one on this edge
//   count    : current number of bits counted
//   terminal : high while count equals WIDTH
// ---------------------------------------------------------------------------
module rx_bit_counter #(
   parameter int WIDTH = 4,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          enable,
   output logic [CW-1:0] count,
   output logic          terminal
);

   // Count register: a clear starts a fresh frame, enable steps one bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   // Terminal count is decoded straight from the register
   always_comb begin
      terminal = (count == CW'(WIDTH));
   end

endmodule

// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
// Receives framed words (start bit, WIDTH data bits MSB first, even parity,
// stop bit) from a strobed serial stream and presents each word through a
// valid/ack handshake with parity, framing and overrun status.
//   clk        : rising-edge clock shared with the upstream shift register
//   reset      : asynchronous active-high reset
//   serial_in  : serial bit stream, sampled only when bit_en is high
//   bit_en     : bit strobe
//   data_ack   : consumer accepts the held word
//   data_out   : last received word, MSB is the first data bit received
//   data_valid : data_out holds an unconsumed word
//   parity_err : held word failed even parity
//   frame_err  : stop bit of the last frame was not at the stop level
//   overrun    : sticky, a frame completed while a word was still held
//   busy       : a frame is in progress
// ---------------------------------------------------------------------------
module serial_frame_rx
   import serial_frame_rx_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_in,
   input  logic             bit_en,
   input  logic             data_ack,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             parity_err,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int CW = count_width(WIDTH);

   rx_state_t        state;
   rx_state_t        next_state;
   logic [WIDTH-1:0] acc;
   logic             parity_bit;
   logic             cnt_clear;
   logic             cnt_en;
   logic [CW-1:0]    cnt_count;
   logic             cnt_terminal;
   logic             shift_en;
   logic             parity_cap;
   logic             complete;

   rx_bit_counter #(
      .WIDTH(WIDTH),
      .CW   (CW)
   ) u_bit_counter (
      .clk     (clk),
      .reset   (reset),
      .clear   (cnt_clear),
      .enable  (cnt_en),
      .count   (cnt_count),
      .terminal(cnt_terminal)
   );

   // State register; the FSM only moves on strobed edges, which the
   // next-state logic already accounts for
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and per-bit control. Nothing happens without bit_en.
   // The counter holds the number of data bits already taken, so the
   // WIDTH-th bit arrives while it reads WIDTH-1. The terminal guard keeps
   // the counter from wrapping should the state ever be corrupted.
   always_comb begin
      next_state = state;
      cnt_clear  = 1'b0;
      cnt_en     = 1'b0;
      shift_en   = 1'b0;
      parity_cap = 1'b0;
      complete   = 1'b0;
      if (bit_en) begin
         case (state)
            IDLE: begin
               if (serial_in == START_BIT) begin
                  next_state = DATA;
                  cnt_clear  = 1'b1;
               end
            end
            DATA: begin
               shift_en = 1'b1;
               cnt_en   = !cnt_terminal;
               if (cnt_count == CW'(WIDTH - 1)) begin
                  next_state = PARITY;
               end
            end
            PARITY: begin
               parity_cap = 1'b1;
               next_state = STOP;
            end
            STOP: begin
               complete   = 1'b1;
               next_state = IDLE;
            end
            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

   // Shift accumulator and captured parity bit for the frame in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc        <= '0;
         parity_bit <= 1'b0;
      end else begin
         if (shift_en) begin
            acc <= {acc[WIDTH-2:0], serial_in};
         end
         if (parity_cap) begin
            parity_bit <= serial_in;
         end
      end
   end

   // Output word and handshake. Completion always loads the new word; an
   // ack on the same edge retires the old one so no overrun is flagged.
   // Status flags only change at completion so they stay tied to the word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else if (complete) begin
         data_out   <= acc;
         parity_err <= ^{acc, parity_bit};
         frame_err  <= (serial_in != STOP_BIT);
         data_valid <= 1'b1;
         if (data_valid && !data_ack) begin
            overrun <= 1'b1;
         end
      end else if (data_valid && data_ack) begin
         data_valid <= 1'b0;
      end
   end

   // Busy whenever a frame has been opened and not yet closed
   always_comb begin
      busy = (state != IDLE);
   end

endmodule

// File: tb/tb_serial_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_rx
// Directed bench for serial_frame_rx with WIDTH=4. Bits are driven on the
// falling edge and outputs are observed on the following falling edge.
// ---------------------------------------------------------------------------
module tb_serial_frame_rx;

   logic       clk;
   logic       reset;
   logic       serial_in;
   logic       bit_en;
   logic       data_ack;
   logic [3:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int errors;
   int checks;

   serial_frame_rx #(
      .WIDTH(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .serial_in (serial_in),
      .bit_en    (bit_en),
      .data_ack  (data_ack),
      .data_out  (data_out),
      .data_valid(data_valid),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports any difference
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One strobed bit, optional ack on the same edge, then gap idle cycles
   task automatic applyStimulus(input logic b, input int gap, input logic ack);
      @(negedge clk);
      serial_in = b;
      bit_en    = 1'b1;
      data_ack  = ack;
      @(negedge clk);
      serial_in = 1'b0;
      bit_en    = 1'b0;
      data_ack  = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   // Full frame with back-to-back strobes; ack optionally on the stop edge
   task automatic sendFrame(input logic [3:0] d, input logic p, input logic s,
                            input logic ack_on_stop);
      applyStimulus(1'b1, 0, 1'b0);
      for (int i = 3; i >= 0; i--) applyStimulus(d[i], 0, 1'b0);
      applyStimulus(p, 0, 1'b0);
      applyStimulus(s, 0, ack_on_stop);
   endtask

   // Ack pulse with no bit strobe
   task automatic pulseAck();
      @(negedge clk);
      data_ack = 1'b1;
      @(negedge clk);
      data_ack = 1'b0;
   endtask

   // Reset pulse applied between clock edges
   task automatic pulseReset();
      @(negedge clk);
      #2 reset = 1'b1;
      #2 reset = 1'b0;
   endtask

   initial begin
      logic [6:0] gap_bits;
      errors    = 0;
      checks    = 0;
      reset     = 1'b1;
      serial_in = 1'b0;
      bit_en    = 1'b0;
      data_ack  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst data_out", 16'(data_out), 16'h0);
      checkOutput("rst data_valid", 16'(data_valid), 16'h0);
      checkOutput("rst parity_err", 16'(parity_err), 16'h0);
      checkOutput("rst frame_err", 16'(frame_err), 16'h0);
      checkOutput("rst overrun", 16'(overrun), 16'h0);
      checkOutput("rst busy", 16'(busy), 16'h0);

      $display("[TB] bad parity and bad stop, 4'h7");
      sendFrame(4'h7, 1'b0, 1'b1, 1'b0);
      checkOutput("bad data_out", 16'(data_out), 16'h7);
      checkOutput("bad data_valid", 16'(data_valid), 16'h1);
      checkOutput("bad parity_err", 16'(parity_err), 16'h1);
      checkOutput("bad frame_err", 16'(frame_err), 16'h1);
      checkOutput("bad overrun", 16'(overrun), 16'h0);

      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 0, 1'b0);
      checkOutput("mid busy after start", 16'(busy), 16'h1);
      applyStimulus(1'b1, 0, 1'b0);
      applyStimulus(1'b0, 0, 1'b0);
      #2 reset = 1'b1;
      #1;
      checkOutput("mid rst data_out", 16'(data_out), 16'h0);
      checkOutput("mid rst data_valid", 16'(data_valid), 16'h0);
      checkOutput("mid rst parity_err", 16'(parity_err), 16'h0);
      checkOutput("mid rst frame_err", 16'(frame_err), 16'h0);
      checkOutput("mid rst busy", 16'(busy), 16'h0);
      #1 reset = 1'b0;

      $display("[TB] clean frame 4'hA after reset");
      sendFrame(4'hA, 1'b0, 1'b0, 1'b0);
      checkOutput("A data_out", 16'(data_out), 16'hA);
      checkOutput("A data_valid", 16'(data_valid), 16'h1);
      checkOutput("A parity_err", 16'(parity_err), 16'h0);
      checkOutput("A frame_err", 16'(frame_err), 16'h0);
      checkOutput("A busy", 16'(busy), 16'h0);
      pulseAck();
      checkOutput("A ack clears valid", 16'(data_valid), 16'h0);
      pulseAck();
      checkOutput("ack while empty ignored", 16'(data_valid), 16'h0);

      $display("[TB] gapped strobes, 4'h6");
      gap_bits = 7'b1011000;
      for (int i = 6; i >= 1; i--) begin
         applyStimulus(gap_bits[i], 3, 1'b0);
         checkOutput($sformatf("gap busy strobe %0d", 7 - i), 16'(busy), 16'h1);
         checkOutput($sformatf("gap valid strobe %0d", 7 - i), 16'(data_valid), 16'h0);
      end
      applyStimulus(gap_bits[0], 0, 1'b0);
      checkOutput("gap data_valid", 16'(data_valid), 16'h1);
      checkOutput("gap data_out", 16'(data_out), 16'h6);
      checkOutput("gap parity_err", 16'(parity_err), 16'h0);
      checkOutput("gap busy after stop", 16'(busy), 16'h0);
      pulseAck();

      $display("[TB] overrun, 4'h3 then 4'hC");
      sendFrame(4'h3, 1'b0, 1'b0, 1'b0);
      checkOutput("ovr first data_out", 16'(data_out), 16'h3);
      checkOutput("ovr first overrun", 16'(overrun), 16'h0);
      sendFrame(4'hC, 1'b0, 1'b0, 1'b0);
      checkOutput("ovr data_out", 16'(data_out), 16'hC);
      checkOutput("ovr data_valid", 16'(data_valid), 16'h1);
      checkOutput("ovr overrun", 16'(overrun), 16'h1);
      pulseAck();
      checkOutput("ovr valid after ack", 16'(data_valid), 16'h0);
      checkOutput("ovr sticky after ack", 16'(overrun), 16'h1);
      pulseReset();
      checkOutput("ovr cleared by reset", 16'(overrun), 16'h0);

      $display("[TB] ack on completion edge, 4'h1 then 4'hE");
      sendFrame(4'h1, 1'b1, 1'b0, 1'b0);
      checkOutput("sim first data_out", 16'(data_out), 16'h1);
      checkOutput("sim first parity_err", 16'(parity_err), 16'h0);
      sendFrame(4'hE, 1'b1, 1'b0, 1'b1);
      checkOutput("sim data_out", 16'(data_out), 16'hE);
      checkOutput("sim data_valid", 16'(data_valid), 16'h1);
      checkOutput("sim overrun", 16'(overrun), 16'h0);
      pulseAck();
      checkOutput("sim next ack clears", 16'(data_valid), 16'h0);

      $display("[TB] idle noise");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 0, 1'b0);
         checkOutput($sformatf("noise busy %0d", i), 16'(busy), 16'h0);
      end
      checkOutput("noise data_out", 16'(data_out), 16'hE);
      checkOutput("noise data_valid", 16'(data_valid), 16'h0);
      checkOutput("noise overrun", 16'(overrun), 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
